// File: rtl/ir_pkg.sv
//------------------------------------------------------------------------------
// ir_pkg : letter width, letter range and receive-framing state encoding
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ir_pkg;
  localparam int LETTER_W   = 5;
  localparam int MAX_LETTER = 25;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RX   = 1'b1
  } rx_state_t;
endpackage

`default_nettype wire

// File: rtl/letter_fifo.sv
//------------------------------------------------------------------------------
// letter_fifo : first-word fall-through FIFO on distributed RAM
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module letter_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             w_wr, w_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A write into a full FIFO is only legal when the head leaves on the same edge.
  assign w_rd = rd_en_i && !empty_o;
  assign w_wr = wr_en_i && (!full_o || w_rd);

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({w_wr, w_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ir_rx_letter_buffer.sv
//------------------------------------------------------------------------------
// ir_rx_letter_buffer : buffers decoded IR letters and frames messages by idle gap
// Optional statistics outputs enabled by defining IR_RX_STATS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ir_rx_letter_buffer
  import ir_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 20_000_000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [LETTER_W-1:0]       code_in,
  input  logic                      new_code_in,
  input  logic [2:0]                error_in,
  output logic [LETTER_W-1:0]       data_out,
  output logic                      data_valid_out,
  input  logic                      data_ready_in,
  output logic [$clog2(DEPTH):0]    count_out,
  output logic                      msg_active_out,
  output logic                      msg_done_out,
`ifdef IR_RX_STATS_EN
  output logic [15:0]               rx_count_out,
  output logic [15:0]               drop_count_out,
`endif
  output logic                      overflow_out
);

  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic                w_accept, w_pop, w_push, w_ovf_drop;
  logic                w_empty, w_full;
  logic [LETTER_W-1:0] w_head;

  rx_state_t           state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                done_q, done_d;
  logic                overflow_q;

  assign w_accept   = new_code_in && (error_in == 3'd0) &&
                      (code_in <= LETTER_W'(MAX_LETTER));
  assign w_pop      = data_valid_out && data_ready_in;
  assign w_push     = w_accept && (!w_full || w_pop);
  assign w_ovf_drop = w_accept && w_full && !w_pop;

  letter_fifo #(
    .WIDTH (LETTER_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_in),
    .rst_ni    (rst_in),
    .wr_en_i   (w_push),
    .wr_data_i (code_in),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head),
    .empty_o   (w_empty),
    .full_o    (w_full),
    .count_o   (count_out)
  );

  // Storage is not reset, so the head is masked to keep data_out at 0 while empty.
  assign data_valid_out = !w_empty;
  assign data_out       = w_empty ? '0 : w_head;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d = RX;
          gap_d   = '0;
        end
      end
      RX: begin
        if (new_code_in) begin
          gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          gap_d   = '0;
          done_d  = 1'b1;
        end else if (gap_q != '1) begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      overflow_q <= overflow_q | w_ovf_drop;
    end
  end

  assign msg_active_out = (state_q == RX);
  assign msg_done_out   = done_q;
  assign overflow_out   = overflow_q;

`ifdef IR_RX_STATS_EN
  logic        w_discard;
  logic [15:0] rx_cnt_q, drop_cnt_q;

  assign w_discard = new_code_in && !w_accept;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (w_push && (rx_cnt_q != 16'hFFFF)) begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
      if ((w_discard || w_ovf_drop) && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign rx_count_out   = rx_cnt_q;
  assign drop_count_out = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ir_rx_letter_buffer.sv
//------------------------------------------------------------------------------
// tb_ir_rx_letter_buffer : directed vectors and corner sequences for the letter buffer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ir_rx_letter_buffer;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [4:0] code_in;
  logic       new_code_in;
  logic [2:0] error_in;
  logic [4:0] data_out;
  logic       data_valid_out;
  logic       data_ready_in;
  logic [2:0] count_out;
  logic       msg_active_out;
  logic       msg_done_out;
  logic       overflow_out;
`ifdef IR_RX_STATS_EN
  logic [15:0] rx_count_out;
  logic [15:0] drop_count_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  ir_rx_letter_buffer #(
    .DEPTH      (4),
    .GAP_CYCLES (10)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .code_in        (code_in),
    .new_code_in    (new_code_in),
    .error_in       (error_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out),
    .data_ready_in  (data_ready_in),
    .count_out      (count_out),
    .msg_active_out (msg_active_out),
    .msg_done_out   (msg_done_out),
`ifdef IR_RX_STATS_EN
    .rx_count_out   (rx_count_out),
    .drop_count_out (drop_count_out),
`endif
    .overflow_out   (overflow_out)
  );

  typedef struct {
    logic       nw;
    logic [4:0] code;
    logic [2:0] err;
    logic       rdy;
    logic       e_valid;
    logic [4:0] e_data;
    logic [2:0] e_count;
    logic       e_active;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Inputs applied #1 after an edge take effect on the next edge; outputs sampled #1 after it.
  task automatic step(input logic nw, input logic [4:0] code, input logic [2:0] err,
                      input logic rdy);
    new_code_in   = nw;
    code_in       = code;
    error_in      = err;
    data_ready_in = rdy;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int q[$];
    int sent;
    int done_seen;
    logic nw;
    logic rdy;
    logic pop;

    rst_in        = 1'b0;
    new_code_in   = 1'b0;
    code_in       = '0;
    error_in      = '0;
    data_ready_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset_valid",  32'(data_valid_out), 0);
    chk("reset_data",   32'(data_out),       0);
    chk("reset_count",  32'(count_out),      0);
    chk("reset_active", 32'(msg_active_out), 0);
    chk("reset_done",   32'(msg_done_out),   0);
    chk("reset_ovf",    32'(overflow_out),   0);
    rst_in = 1'b1;
    step(1'b0, 5'd0, 3'd0, 1'b0);

    //          nw    code   err     rdy   valid data   cnt   active
    vecs[0] = '{1'b1, 5'd7,  3'd0,   1'b1, 1'b1, 5'd7,  3'd1, 1'b1};
    vecs[1] = '{1'b1, 5'd4,  3'd0,   1'b1, 1'b1, 5'd4,  3'd1, 1'b1};
    vecs[2] = '{1'b1, 5'd11, 3'd0,   1'b1, 1'b1, 5'd11, 3'd1, 1'b1};
    vecs[3] = '{1'b0, 5'd0,  3'd0,   1'b1, 1'b0, 5'd0,  3'd0, 1'b1};
    vecs[4] = '{1'b1, 5'd26, 3'd0,   1'b1, 1'b0, 5'd0,  3'd0, 1'b1};
    vecs[5] = '{1'b1, 5'd3,  3'b010, 1'b1, 1'b0, 5'd0,  3'd0, 1'b1};
    vecs[6] = '{1'b1, 5'd25, 3'd0,   1'b0, 1'b1, 5'd25, 3'd1, 1'b1};
    vecs[7] = '{1'b1, 5'd0,  3'd0,   1'b0, 1'b1, 5'd25, 3'd2, 1'b1};
    vecs[8] = '{1'b0, 5'd0,  3'd0,   1'b1, 1'b1, 5'd0,  3'd1, 1'b1};
    vecs[9] = '{1'b0, 5'd0,  3'd0,   1'b1, 1'b0, 5'd0,  3'd0, 1'b1};

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].nw, vecs[i].code, vecs[i].err, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i),  32'(data_valid_out), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i),   32'(data_out),       32'(vecs[i].e_data));
      chk($sformatf("vec%0d_count", i),  32'(count_out),      32'(vecs[i].e_count));
      chk($sformatf("vec%0d_active", i), 32'(msg_active_out), 32'(vecs[i].e_active));
    end
    chk("table_ovf", 32'(overflow_out), 0);
`ifdef IR_RX_STATS_EN
    chk("stats_rx",   32'(rx_count_out),   5);
    chk("stats_drop", 32'(drop_count_out), 2);
`endif

    for (int i = 0; i < 30 && msg_active_out; i++) step(1'b0, 5'd0, 3'd0, 1'b1);
    chk("idle_reached", 32'(msg_active_out), 0);
    step(1'b0, 5'd0, 3'd0, 1'b1);

    // Gap framing: 10 active cycles, then one done pulse while back in IDLE.
    step(1'b1, 5'd1, 3'd0, 1'b1);
    chk("gap_start_active", 32'(msg_active_out), 1);
    for (int k = 1; k < 10; k++) begin
      step(1'b0, 5'd0, 3'd0, 1'b1);
      chk($sformatf("gap%0d_active", k), 32'(msg_active_out), 1);
      chk($sformatf("gap%0d_done", k),   32'(msg_done_out),   0);
    end
    step(1'b0, 5'd0, 3'd0, 1'b1);
    chk("gap_end_active", 32'(msg_active_out), 0);
    chk("gap_end_done",   32'(msg_done_out),   1);
    step(1'b0, 5'd0, 3'd0, 1'b1);
    chk("gap_after_done", 32'(msg_done_out), 0);

    // Overflow at DEPTH=4, read-back, then push+pop while full.
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 5'(10 + k), 3'd0, 1'b0);
      if (k == 3) chk("ovf_before", 32'(overflow_out), 0);
    end
    chk("ovf_count", 32'(count_out),    4);
    chk("ovf_flag",  32'(overflow_out), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_read%0d", k), 32'(data_out), 32'(10 + k));
      step(1'b0, 5'd0, 3'd0, 1'b1);
    end
    chk("ovf_drained", 32'(data_valid_out), 0);
    for (int k = 0; k < 4; k++) step(1'b1, 5'(20 + k), 3'd0, 1'b0);
    step(1'b1, 5'd24, 3'd0, 1'b1);
    chk("full_pp_count", 32'(count_out),    4);
    chk("full_pp_ovf",   32'(overflow_out), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_pp_read%0d", k), 32'(data_out), 32'(21 + k));
      step(1'b0, 5'd0, 3'd0, 1'b1);
    end
    chk("full_pp_empty", 32'(count_out), 0);

    // Asynchronous reset mid-message with 3 letters buffered.
    for (int k = 0; k < 3; k++) step(1'b1, 5'(k + 2), 3'd0, 1'b0);
    chk("pre_rst_count",  32'(count_out),      3);
    chk("pre_rst_active", 32'(msg_active_out), 1);
    new_code_in = 1'b0;
    rst_in      = 1'b0;
    #1;
    chk("rst_valid",  32'(data_valid_out), 0);
    chk("rst_data",   32'(data_out),       0);
    chk("rst_count",  32'(count_out),      0);
    chk("rst_active", 32'(msg_active_out), 0);
    chk("rst_ovf",    32'(overflow_out),   0);
    @(posedge clk_in);
    #1;
    rst_in    = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 5'd0, 3'd0, 1'b0);
      if (msg_done_out) done_seen++;
    end
    chk("rst_no_done", 32'(done_seen), 0);

    // Pointer wrap: stream 10 letters against a reference queue.
    sent = 0;
    for (int i = 0; i < 80 && (sent < 10 || q.size() > 0); i++) begin
      nw  = (sent < 10) && (i % 2 == 0);
      rdy = ((i % 4) < 2);
      pop = rdy && (q.size() > 0);
      step(nw, 5'(sent + 2), 3'd0, rdy);
      if (pop) void'(q.pop_front());
      if (nw) begin
        q.push_back(sent + 2);
        sent++;
      end
      chk($sformatf("wrap%0d_count", i), 32'(count_out), 32'(q.size()));
      if (q.size() > 0) chk($sformatf("wrap%0d_data", i), 32'(data_out), 32'(q[0]));
    end
    chk("wrap_sent",    32'(sent),         10);
    chk("wrap_drained", 32'(q.size()),     0);
    chk("wrap_no_ovf",  32'(overflow_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ir_rx_letter_buffer.md
IR_RX_LETTER_BUFFER -- requirements
Module: ir_rx_letter_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries; the value SHALL be a power of two, 4..1024.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 20_000_000, meaning the idle clk_in cycles (200 ms at 100 MHz) that end a message.
REQ-003 clk_in  input  1  sole clock, 100 MHz system domain.
REQ-004 rst_in  input  1  reset, asynchronous assert, active-low.
REQ-005 code_in  input  5  letter code from the IR decoder (0=A .. 25=Z).
REQ-006 new_code_in  input  1  single-cycle strobe; code_in valid this cycle.
REQ-007 error_in  input  3  IR decoder error flags; nonzero means the frame is bad.
REQ-008 data_out  output  5  letter at the FIFO head.
REQ-009 data_valid_out  output  1  data_out holds a valid letter.
REQ-010 data_ready_in  input  1  downstream (enigma decoder) accepts data_out.
REQ-011 count_out  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 msg_active_out  output  1  a message is being received.
REQ-013 msg_done_out  output  1  single-cycle pulse at the end of a message.
REQ-014 overflow_out  output  1  sticky flag: a letter was dropped because the FIFO was full.

Function
REQ-015 A letter SHALL be accepted when new_code_in=1, error_in==0 and code_in<=25.
REQ-016 A code with new_code_in=1 and either code_in>25 or error_in!=0 SHALL be discarded without changing FIFO contents.
REQ-017 An accepted letter SHALL appear on data_out, with data_valid_out=1, on the cycle after acceptance when the FIFO was empty (1-cycle latency).
REQ-018 A pop SHALL occur on any cycle where data_valid_out=1 and data_ready_in=1; data_out SHALL be stable while valid and not ready.
REQ-019 The FIFO SHALL be first-word fall-through, and read and write pointers SHALL wrap modulo DEPTH.
REQ-020 A push while full SHALL be dropped and set overflow_out=1, except when a pop occurs in the same cycle, in which case both SHALL succeed.
REQ-021 A simultaneous push and pop at count 0 SHALL NOT bypass: the letter is stored and valid the next cycle.
REQ-022 count_out SHALL be incremented on push only, decremented on pop only, and unchanged on both or neither.
REQ-023 The framing FSM SHALL have states IDLE and RX, with IDLE as the reset state.
REQ-024 In IDLE, an accepted letter SHALL move the FSM to RX and clear the gap counter.
REQ-025 In RX, each new_code_in (valid or not) SHALL clear the gap counter; otherwise the counter SHALL increment each cycle.
REQ-026 In RX, when the gap counter reaches GAP_CYCLES-1, the FSM SHALL go to IDLE and pulse msg_done_out for exactly 1 cycle.
REQ-027 msg_active_out SHALL be 1 exactly when the FSM is in RX.
REQ-028 The gap counter SHALL saturate and SHALL be $clog2(GAP_CYCLES) bits wide.
REQ-029 Framing SHALL be independent of FIFO occupancy, and msg_done_out SHALL NOT flush the FIFO.

Reset
REQ-030 While rst_in=0, the FIFO SHALL be empty, the pointers and count 0, and the FSM in IDLE with a cleared gap counter.
REQ-031 While rst_in=0, outputs SHALL be: data_valid_out=0, data_out=0, count_out=0, msg_active_out=0, msg_done_out=0, overflow_out=0.
REQ-032 Reset asserted mid-message SHALL discard the buffered letters and SHALL NOT pulse msg_done_out.
REQ-033 FIFO storage contents need not be cleared on reset.

Configuration
REQ-034 With IR_RX_STATS_EN defined, the block SHALL add outputs rx_count_out[15:0] (accepted letters) and drop_count_out[15:0] (discarded plus overflow-dropped).
REQ-035 The IR_RX_STATS_EN counters SHALL saturate at 16'hFFFF and reset to 0.
REQ-036 Without IR_RX_STATS_EN, these ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-037 Package ir_pkg SHALL hold LETTER_W=5, MAX_LETTER=25 and the enum rx_state_t {IDLE, RX}, shared with ir_transmitter and ir_decoder users.
REQ-038 The FIFO SHALL be a sub-module, letter_fifo (WIDTH, DEPTH parameters, with inferred distributed RAM), instantiated once.
REQ-039 The framing FSM SHALL reside in the top of ir_rx_letter_buffer.

Verification
REQ-040 Scenario: push codes 7, 4, 11 with data_ready_in=1 -> data_out 7, 4, 11 in order, each valid 1 cycle after its push, and count returns to 0.
REQ-041 Scenario: push code 26, then code 3 with error_in=3'b010 -> count_out stays 0, data_valid_out=0, and drop_count_out=2 when IR_RX_STATS_EN is defined.
REQ-042 Scenario: with DEPTH=4 and ready=0, push 5 letters -> count_out=4, overflow_out=1, and the first 4 letters are read back; with a simultaneous push and pop at full, count stays 4 and overflow_out is unchanged.
REQ-043 Scenario: with GAP_CYCLES=10, push 1 letter and wait -> msg_active_out=1 for 10 cycles, then a single msg_done_out pulse, then IDLE.
REQ-044 Scenario: rst_in=0 asserted for 1 cycle mid-message with 3 letters buffered -> all outputs reset immediately, and no msg_done_out pulse.
REQ-045 Scenario: pointer wrap with DEPTH=4, streaming 10 letters with alternating ready -> letters are output in order with no loss.
